// File: rtl/preif_stage.sv
// Pre-IF stage: picks the next fetch PC, drives the instruction SRAM request
// and hands accepted fetch PCs (or a fetch address error) to IF.
module preif_stage #(
    parameter logic [31:0] RESET_PC      = 32'h1C000000,
    parameter logic [5:0]  ECODE_ADE     = 6'h08,
    parameter logic [8:0]  ESUBCODE_ADEF = 9'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        wb_ex,
    input  logic [31:0] ex_entry,
    input  logic        ertn_flush,
    input  logic [31:0] ex_ra,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        IF_allowin,
    output logic        preif_to_if_valid,
    output logic [31:0] preif_to_if_pc,
    output logic        preif_to_if_ex,
    output logic [14:0] preif_to_if_ex_code,
    output logic        preif_to_if_cancel
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_r;
    logic [31:0] hold_addr;
    logic [31:0] redir_pc;
    logic        redir_valid;
    logic        discard;

    logic        live_redir;
    logic [31:0] live_target;
    logic [31:0] nextpc;
    logic        adef;

    logic        req_c;
    logic [31:0] addr_c;
    logic        valid_c;
    logic [31:0] pc_c;
    logic        ex_c;
    logic        cancel_c;
    logic        commit_c;

    always_comb begin
        live_redir  = wb_ex | ertn_flush | br_taken;
        live_target = wb_ex      ? ex_entry :
                      ertn_flush ? ex_ra    : br_target;
        nextpc      = live_redir  ? live_target :
                      redir_valid ? redir_pc    : pc_r + 32'd4;
        adef        = |nextpc[1:0];
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        addr_c    = '0;
        valid_c   = 1'b0;
        pc_c      = '0;
        ex_c      = 1'b0;
        cancel_c  = 1'b0;
        commit_c  = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_c  = IF_allowin & ~adef;
                addr_c = {nextpc[31:2], 2'b00};
                if (req_c) begin
                    commit_c = 1'b1;
                    if (inst_sram_addr_ok) begin
                        valid_c = 1'b1;
                        pc_c    = nextpc;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end else if (IF_allowin) begin
                    commit_c = 1'b1;
                    valid_c  = 1'b1;
                    ex_c     = 1'b1;
                    pc_c     = nextpc;
                end
            end
            S_HOLD: begin
                req_c  = 1'b1;
                addr_c = hold_addr;
                if (inst_sram_addr_ok) begin
                    if (discard | live_redir) begin
                        cancel_c  = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (IF_allowin) begin
                        valid_c   = 1'b1;
                        pc_c      = hold_addr;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (IF_allowin) begin
                    state_nxt = S_IDLE;
                    if (discard | live_redir) begin
                        cancel_c = 1'b1;
                    end else begin
                        valid_c = 1'b1;
                        pc_c    = hold_addr;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc_r        <= RESET_PC - 32'd4;
            hold_addr   <= '0;
            redir_pc    <= '0;
            redir_valid <= 1'b0;
            discard     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (commit_c) begin
                pc_r        <= nextpc;
                hold_addr   <= nextpc;
                redir_valid <= 1'b0;
            end
            if (live_redir && (state != S_IDLE || !IF_allowin)) begin
                redir_pc    <= live_target;
                redir_valid <= 1'b1;
            end
            if (live_redir && state != S_IDLE)
                discard <= 1'b1;
            // The cancel pulse consumes the stale flag, even if a redirect lands on the same cycle.
            if (cancel_c)
                discard <= 1'b0;
        end
    end

    assign inst_sram_req       = req_c & ~reset;
    assign inst_sram_addr      = reset ? '0 : addr_c;
    assign inst_sram_wr        = 1'b0;
    assign inst_sram_size      = 2'd2;
    assign inst_sram_wstrb     = 4'h0;
    assign inst_sram_wdata     = '0;
    assign preif_to_if_valid   = valid_c & ~reset;
    assign preif_to_if_pc      = reset ? '0 : pc_c;
    assign preif_to_if_ex      = ex_c & ~reset;
    assign preif_to_if_ex_code = preif_to_if_ex ? {ESUBCODE_ADEF, ECODE_ADE} : 15'd0;
    assign preif_to_if_cancel  = cancel_c & ~reset;

endmodule

// File: tb/tb_preif_stage.sv
// Directed bench for preif_stage: inputs change on the falling edge and
// outputs are compared 1 ns later against hand-computed values.
module tb_preif_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_taken, wb_ex, ertn_flush;
    logic [31:0] br_target, ex_entry, ex_ra;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata, inst_sram_addr;
    logic        inst_sram_addr_ok, IF_allowin;
    logic        preif_to_if_valid, preif_to_if_ex, preif_to_if_cancel;
    logic [31:0] preif_to_if_pc;
    logic [14:0] preif_to_if_ex_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    preif_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .br_taken            (br_taken),
        .br_target           (br_target),
        .wb_ex               (wb_ex),
        .ex_entry            (ex_entry),
        .ertn_flush          (ertn_flush),
        .ex_ra               (ex_ra),
        .inst_sram_req       (inst_sram_req),
        .inst_sram_wr        (inst_sram_wr),
        .inst_sram_size      (inst_sram_size),
        .inst_sram_wstrb     (inst_sram_wstrb),
        .inst_sram_wdata     (inst_sram_wdata),
        .inst_sram_addr      (inst_sram_addr),
        .inst_sram_addr_ok   (inst_sram_addr_ok),
        .IF_allowin          (IF_allowin),
        .preif_to_if_valid   (preif_to_if_valid),
        .preif_to_if_pc      (preif_to_if_pc),
        .preif_to_if_ex      (preif_to_if_ex),
        .preif_to_if_ex_code (preif_to_if_ex_code),
        .preif_to_if_cancel  (preif_to_if_cancel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic allow, input logic ok,
                         input logic br, input logic [31:0] bt,
                         input logic wx, input logic [31:0] ent,
                         input logic er, input logic [31:0] ra);
        IF_allowin        = allow;
        inst_sram_addr_ok = ok;
        br_taken          = br;
        br_target         = bt;
        wb_ex             = wx;
        ex_entry          = ent;
        ertn_flush        = er;
        ex_ra             = ra;
    endtask

    // One active cycle: apply inputs after the falling edge, settle 1 ns.
    task automatic cyc(input logic allow, input logic ok,
                       input logic br = 1'b0, input logic [31:0] bt = '0,
                       input logic wx = 1'b0, input logic [31:0] ent = '0,
                       input logic er = 1'b0, input logic [31:0] ra = '0);
        @(negedge clk);
        reset = 1'b0;
        drive(allow, ok, br, bt, wx, ent, er, ra);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc,
                              input logic ex, input logic cancel);
        check({tag, ".req"}, 32'(inst_sram_req), 32'(req));
        if (req)
            check({tag, ".addr"}, inst_sram_addr, addr);
        check({tag, ".valid"}, 32'(preif_to_if_valid), 32'(valid));
        if (valid)
            check({tag, ".pc"}, preif_to_if_pc, pc);
        check({tag, ".ex"}, 32'(preif_to_if_ex), 32'(ex));
        check({tag, ".ex_code"}, 32'(preif_to_if_ex_code), ex ? 32'h0008 : 32'h0);
        check({tag, ".cancel"}, 32'(preif_to_if_cancel), 32'(cancel));
    endtask

    // Holds reset for two cycles with fetch enabled; leaves reset high.
    task automatic do_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset = 1'b1;
            drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
            #1;
            check({tag, ".rst_req"}, 32'(inst_sram_req), 32'h0);
            check({tag, ".rst_valid"}, 32'(preif_to_if_valid), 32'h0);
            check({tag, ".rst_cancel"}, 32'(preif_to_if_cancel), 32'h0);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);

        // Sequential fetch after reset
        do_reset("r0");
        cyc(1, 1); expect_out("seq0", 1, 32'h1C000000, 1, 32'h1C000000, 0, 0);
        check("wr", 32'(inst_sram_wr), 32'h0);
        check("size", 32'(inst_sram_size), 32'h2);
        check("wstrb", 32'(inst_sram_wstrb), 32'h0);
        check("wdata", inst_sram_wdata, 32'h0);
        cyc(1, 1); expect_out("seq1", 1, 32'h1C000004, 1, 32'h1C000004, 0, 0);
        cyc(1, 1); expect_out("seq2", 1, 32'h1C000008, 1, 32'h1C000008, 0, 0);

        // addr_ok withheld 3 cycles at 1C000008
        do_reset("r1");
        cyc(1, 1); expect_out("st0", 1, 32'h1C000000, 1, 32'h1C000000, 0, 0);
        cyc(1, 1); expect_out("st1", 1, 32'h1C000004, 1, 32'h1C000004, 0, 0);
        cyc(1, 0); expect_out("st2", 1, 32'h1C000008, 0, 0, 0, 0);
        cyc(1, 0); expect_out("st3", 1, 32'h1C000008, 0, 0, 0, 0);
        cyc(1, 0); expect_out("st4", 1, 32'h1C000008, 0, 0, 0, 0);
        cyc(1, 1); expect_out("st5", 1, 32'h1C000008, 1, 32'h1C000008, 0, 0);
        cyc(1, 1); expect_out("st6", 1, 32'h1C00000C, 1, 32'h1C00000C, 0, 0);

        // Branch during the second HOLD cycle -> cancel, then fetch the target
        cyc(1, 0); expect_out("br0", 1, 32'h1C000010, 0, 0, 0, 0);
        cyc(1, 0); expect_out("br1", 1, 32'h1C000010, 0, 0, 0, 0);
        cyc(1, 0, 1, 32'h1C000100);
        expect_out("br2", 1, 32'h1C000010, 0, 0, 0, 0);
        cyc(1, 1); expect_out("br3", 1, 32'h1C000010, 0, 0, 0, 1);
        cyc(1, 1); expect_out("br4", 1, 32'h1C000100, 1, 32'h1C000100, 0, 0);

        // Exception beats a simultaneous branch
        cyc(1, 1, 1, 32'h1C000100, 1, 32'h1C008000);
        expect_out("pri", 1, 32'h1C008000, 1, 32'h1C008000, 0, 0);

        // Misaligned branch target -> ADEF handed to IF, no request
        cyc(1, 1, 1, 32'h1C000102);
        expect_out("adef", 0, 0, 1, 32'h1C000102, 1, 0);
        cyc(1, 1, 0, '0, 1, 32'h1C008000);
        expect_out("adef_rec", 1, 32'h1C008000, 1, 32'h1C008000, 0, 0);

        // Accepted while IF stalled, then ertn before allowin -> cancel
        cyc(1, 0); expect_out("w0", 1, 32'h1C008004, 0, 0, 0, 0);
        cyc(0, 1); expect_out("w1", 1, 32'h1C008004, 0, 0, 0, 0);
        cyc(0, 0, 0, '0, 0, '0, 1, 32'h1C000200);
        expect_out("w2", 0, 0, 0, 0, 0, 0);
        cyc(1, 0); expect_out("w3", 0, 0, 0, 0, 0, 1);
        cyc(1, 1); expect_out("w4", 1, 32'h1C000200, 1, 32'h1C000200, 0, 0);

        // Accepted while IF stalled, clean handover later
        cyc(1, 0); expect_out("h0", 1, 32'h1C000204, 0, 0, 0, 0);
        cyc(0, 1); expect_out("h1", 1, 32'h1C000204, 0, 0, 0, 0);
        cyc(0, 0); expect_out("h2", 0, 0, 0, 0, 0, 0);
        cyc(1, 0); expect_out("h3", 0, 0, 1, 32'h1C000204, 0, 0);
        cyc(1, 1); expect_out("h4", 1, 32'h1C000208, 1, 32'h1C000208, 0, 0);

        // Redirect while IF stalled in IDLE is buffered
        cyc(0, 1, 1, 32'h1C000300);
        expect_out("b0", 0, 0, 0, 0, 0, 0);
        cyc(1, 1); expect_out("b1", 1, 32'h1C000300, 1, 32'h1C000300, 0, 0);

        // Reset while in HOLD restarts from RESET_PC without a cancel
        cyc(1, 0); expect_out("rh0", 1, 32'h1C000304, 0, 0, 0, 0);
        do_reset("r2");
        cyc(1, 1); expect_out("rh1", 1, 32'h1C000000, 1, 32'h1C000000, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
